seq_mm_engine: RTL and testbench
================================

# seq_mm_engine

Multi-cycle, handshaked matrix multiplier computing C = A x B for parametrised A_ROWS x A_COLUMNS_B_ROWS by A_COLUMNS_B_ROWS x B_COLUMNS integer matrices.
- It is the successor to the single-cycle combinational engine in the matrix-multiply family.
- The dot-product loop is folded over time: each cycle adds K_STEP rank-1 outer-product terms into an array of A_ROWS*B_COLUMNS accumulators.
- Adds valid/ready flow control on both sides, a runtime signed/unsigned mode and an optional accumulate-into-C mode.

## Interface
- DATA_WIDTH, 8: operand element width.
- A_ROWS, 4: rows of A and C.
- B_COLUMNS, 4: columns of B and C.
- A_COLUMNS_B_ROWS, 4: inner dimension.
- K_STEP, 1: inner-dimension terms summed per compute cycle. Must divide A_COLUMNS_B_ROWS (elaboration-time assertion).
- C_DATA_WIDTH, 2*DATA_WIDTH+$clog2(A_COLUMNS_B_ROWS): accumulator/output element width.
- clk  in  1  single clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  operands valid.
- ready_o  out  1  engine can accept operands.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned. Sampled on accept.
- accumulate_i  in  1  present only with SEQ_MM_ENGINE_ACCUM_EN. Sampled on accept.
- a_i  in  DATA_WIDTH x A_ROWS*A_COLUMNS_B_ROWS  A, row-major.
- b_i  in  DATA_WIDTH x A_COLUMNS_B_ROWS*B_COLUMNS  B, row-major.
- valid_o  out  1  c_o holds a complete result.
- ready_i  in  1  consumer accepts result.
- c_o  out  C_DATA_WIDTH x A_ROWS*B_COLUMNS  C, row-major, driven directly from the accumulators.

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- Reset (reset_ni low, asynchronous) forces:
  - state=IDLE, k counter=0, all accumulators=0;
  - hence c_o=0, valid_o=0, ready_o=1.
  - Inputs are ignored while reset is asserted.
  - Reset mid-COMPUTE or mid-DONE discards the operation; no partial result is ever flagged valid.
- Decoded outputs: ready_o = (state==IDLE); valid_o = (state==DONE). Both are decoded from registered state only, with no combinational input-to-output path.
- IDLE:
  - On valid_i && ready_o: latch a_i, b_i and signed_i into operand registers; clear accumulators (unless accumulate mode applies); set k=0; go to COMPUTE.
  - Otherwise hold; c_o keeps its last value.
- COMPUTE:
  - Each cycle, for every (i,j): acc[i][j] += sum over s in 0..K_STEP-1 of A[i][k+s]*B[k+s][j]; then k += K_STEP.
  - When k+K_STEP == A_COLUMNS_B_ROWS, perform the final update and go to DONE.
  - valid_i is ignored (ready_o=0).
- DONE:
  - c_o is stable.
  - On ready_i, go to IDLE at the next edge; valid_o deasserts.
  - ready_i low holds the result indefinitely.
- Arithmetic:
  - Operands are sign-extended (signed_i=1) or zero-extended (signed_i=0) to C_DATA_WIDTH before multiplying.
  - Sums are computed at C_DATA_WIDTH.
  - Default width is full precision for a single product: unsigned max 255*255*4=260100 and signed extreme (-128)*(-128)*4=65536 both fit in 18 bits.
- Latched operands are used during COMPUTE; a_i/b_i may change freely after accept.

## Timing
- Let N = A_COLUMNS_B_ROWS/K_STEP.
- Accept edge E0 → COMPUTE edges E1..EN → valid_o high after EN. Latency is N cycles from accept to valid_o.
- Result handshake at edge Ed → ready_o high after Ed. The next accept is possible at Ed+1.
- Minimum initiation interval is N+2 cycles (defaults: 6).
- ready_i asserted in advance has no effect until DONE. With it held high, valid_o is a one-cycle pulse.

## Configuration
- SEQ_MM_ENGINE_ACCUM_EN defined:
  - Adds the accumulate_i port.
  - If accumulate_i=1 on accept, accumulators are not cleared, giving C_new = C_prev + A x B.
  - Overflow wraps modulo 2^C_DATA_WIDTH; no saturation.
- Undefined: no port, and accumulators are always cleared on accept.

## Test plan
- Reset/idle: hold reset_ni low 3 cycles, then release → valid_o=0, ready_o=1, all c_o=0. No response to valid_i=1 asserted during reset.
- Unsigned identity:
  - Stimulus: A=I (4x4 identity), B elements 1..16, signed_i=0, ready_i=1.
  - Required: valid_o exactly 4 cycles after accept; c_o=1..16; valid_o pulses for 1 cycle; ready_o returns 1 the next cycle.
- Signed extremes:
  - Stimulus: all A=0x80, all B=0x80, signed_i=1.
  - Required: every c_o=65536.
  - Same operands with signed_i=0: every c_o=65536 (128*128*4).
  - All A=B=0xFF with signed_i=0: every c_o=260100.
- Backpressure and latching:
  - Stimulus: ready_i=0 for 10 cycles after valid_o rises; change a_i/b_i during COMPUTE; assert valid_i continuously.
  - Required: c_o unchanged while valid_o is held; the result matches the operands latched at accept; no second accept until the result handshake completes.
- K_STEP=2, and K_STEP=4 with the same random matrices → identical c_o with latencies 2 and 1.
  - Also assert reset_ni mid-COMPUTE → valid_o never rises and c_o=0.
- With SEQ_MM_ENGINE_ACCUM_EN:
  - Stimulus: A=I, B=all 5; repeat twice with accumulate_i=1.
  - Required: c_o=diag-independent all 10.
  - Then accumulate_i=0 → all 5.
  - Accumulating all-0xFF unsigned products 2^18/260100+1 times wraps modulo 2^18.

Source files
------------

// File: rtl/seq_mm_engine.sv
// Multi-cycle handshaked integer matrix multiplier, C = A x B, folding K_STEP rank-1 terms per cycle.
// Optional accumulate-into-C mode is enabled by defining SEQ_MM_ENGINE_ACCUM_EN.
module seq_mm_engine #(
  parameter int DATA_WIDTH       = 8,
  parameter int A_ROWS           = 4,
  parameter int B_COLUMNS        = 4,
  parameter int A_COLUMNS_B_ROWS = 4,
  parameter int K_STEP           = 1,
  parameter int C_DATA_WIDTH     = 2*DATA_WIDTH + $clog2(A_COLUMNS_B_ROWS)
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic valid_i,
  output logic ready_o,
  input  logic signed_i,
`ifdef SEQ_MM_ENGINE_ACCUM_EN
  input  logic accumulate_i,
`endif
  input  logic [A_ROWS*A_COLUMNS_B_ROWS-1:0][DATA_WIDTH-1:0]    a_i,
  input  logic [A_COLUMNS_B_ROWS*B_COLUMNS-1:0][DATA_WIDTH-1:0] b_i,
  output logic valid_o,
  input  logic ready_i,
  output logic [A_ROWS*B_COLUMNS-1:0][C_DATA_WIDTH-1:0]         c_o
);

  localparam int KD  = A_COLUMNS_B_ROWS;
  localparam int NA  = A_ROWS*KD;
  localparam int NB  = KD*B_COLUMNS;
  localparam int NC  = A_ROWS*B_COLUMNS;
  localparam int KW  = $clog2(KD+1);
  localparam int AIW = $clog2(NA);
  localparam int BIW = $clog2(NB);

  generate
    if ((A_COLUMNS_B_ROWS % K_STEP) != 0) begin : g_bad_kstep
      $error("K_STEP must divide A_COLUMNS_B_ROWS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  typedef logic [NA-1:0][DATA_WIDTH-1:0] a_mat_t;
  typedef logic [NB-1:0][DATA_WIDTH-1:0] b_mat_t;

  state_t                        state_reg, state_next;
  a_mat_t                        a_reg;
  b_mat_t                        b_reg;
  logic                          signed_reg;
  logic [KW-1:0]                 k_reg;
  logic [NC-1:0][C_DATA_WIDTH-1:0] acc_reg;
  logic [NC-1:0][C_DATA_WIDTH-1:0] step_sum;
  logic                          accept;
  logic                          last_step;
  logic                          clear_acc;

`ifdef SEQ_MM_ENGINE_ACCUM_EN
  assign clear_acc = ~accumulate_i;
`else
  assign clear_acc = 1'b1;
`endif

  function automatic logic [C_DATA_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v, input logic sgn);
    return sgn ? {{(C_DATA_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v}
               : {{(C_DATA_WIDTH-DATA_WIDTH){1'b0}}, v};
  endfunction

  // Products are formed at C_DATA_WIDTH, so signed results wrap correctly in two's complement.
  function automatic logic [C_DATA_WIDTH-1:0] step_term(input a_mat_t a, input b_mat_t b,
                                                        input logic sgn, input logic [KW-1:0] k,
                                                        input int row, input int col);
    logic [C_DATA_WIDTH-1:0] sum;
    int kk;
    sum = '0;
    for (int s = 0; s < K_STEP; s++) begin
      kk  = int'(k) + s;
      sum = sum + ext(a[AIW'(row*KD + kk)], sgn) * ext(b[BIW'(kk*B_COLUMNS + col)], sgn);
    end
    return sum;
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < A_ROWS; gi++) begin : g_row
      for (gj = 0; gj < B_COLUMNS; gj++) begin : g_col
        assign step_sum[gi*B_COLUMNS+gj] = step_term(a_reg, b_reg, signed_reg, k_reg, gi, gj);
      end
    end
  endgenerate

  assign accept    = valid_i && (state_reg == IDLE);
  assign last_step = (k_reg == KW'(KD - K_STEP));

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_i)   state_next = COMPUTE;
      COMPUTE: if (last_step) state_next = DONE;
      DONE:    if (ready_i)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      k_reg      <= '0;
      acc_reg    <= '0;
    end else if (accept) begin
      a_reg      <= a_i;
      b_reg      <= b_i;
      signed_reg <= signed_i;
      k_reg      <= '0;
      if (clear_acc) acc_reg <= '0;
    end else if (state_reg == COMPUTE) begin
      k_reg <= k_reg + KW'(K_STEP);
      for (int e = 0; e < NC; e++) begin
        acc_reg[e] <= acc_reg[e] + step_sum[e];
      end
    end
  end

  assign ready_o = (state_reg == IDLE);
  assign valid_o = (state_reg == DONE);
  assign c_o     = acc_reg;

endmodule

// File: tb/tb_seq_mm_engine.sv
// Directed bench for seq_mm_engine: K_STEP=1 main instance plus K_STEP=2/4 instances sharing stimulus.
// Accumulate-mode scenarios run only when SEQ_MM_ENGINE_ACCUM_EN is defined.
module tb_seq_mm_engine;

  logic clk;
  logic reset_ni;
  logic valid_i;
  logic ready_i;
  logic signed_i;
`ifdef SEQ_MM_ENGINE_ACCUM_EN
  logic accumulate_i;
`endif
  logic [15:0][7:0]  a_i, b_i;
  logic ready1, ready2, ready4;
  logic valid1, valid2, valid4;
  logic [15:0][17:0] c1, c2, c4;

  int vectors;
  int miscompares;

  seq_mm_engine #(.K_STEP(1)) dut1 (
    .clk(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready1), .signed_i(signed_i),
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    .accumulate_i(accumulate_i),
`endif
    .a_i(a_i), .b_i(b_i), .valid_o(valid1), .ready_i(ready_i), .c_o(c1));

  seq_mm_engine #(.K_STEP(2)) dut2 (
    .clk(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready2), .signed_i(signed_i),
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    .accumulate_i(accumulate_i),
`endif
    .a_i(a_i), .b_i(b_i), .valid_o(valid2), .ready_i(ready_i), .c_o(c2));

  seq_mm_engine #(.K_STEP(4)) dut4 (
    .clk(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready4), .signed_i(signed_i),
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    .accumulate_i(accumulate_i),
`endif
    .a_i(a_i), .b_i(b_i), .valid_o(valid4), .ready_i(ready_i), .c_o(c4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference product computed with plain integer arithmetic, truncated to 18 bits.
  function automatic logic [15:0][17:0] model(input logic [15:0][7:0] a, input logic [15:0][7:0] b,
                                               input logic sgn);
    logic [15:0][17:0] r;
    int sum, av, bv;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sum = 0;
        for (int k = 0; k < 4; k++) begin
          av  = sgn ? int'($signed(a[i*4+k])) : int'(a[i*4+k]);
          bv  = sgn ? int'($signed(b[k*4+j])) : int'(b[k*4+j]);
          sum = sum + av*bv;
        end
        r[i*4+j] = sum[17:0];
      end
    end
    return r;
  endfunction

  // Presents one operand set, returns cycles from accept until valid_o of the K_STEP=1 instance.
  task automatic run_op(input logic [15:0][7:0] a, input logic [15:0][7:0] b, input logic sgn,
                        input logic acc, output int lat);
    a_i      = a;
    b_i      = b;
    signed_i = sgn;
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    accumulate_i = acc;
`else
    if (acc) $display("note: accumulate request ignored in this build");
`endif
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    vectors++;
    if (ready1 !== 1'b0) begin
      miscompares++;
      $display("FAIL accept: ready_o=%b after accept edge, required 0", ready1);
    end
    lat = 0;
    while (valid1 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    $display("op sgn=%0b acc=%0b latency=%0d c[0]=%0d c[15]=%0d", sgn, acc, lat, c1[0], c1[15]);
  endtask

  task automatic test_reset;
    reset_ni = 1'b0;
    valid_i  = 1'b1;
    ready_i  = 1'b1;
    signed_i = 1'b0;
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    accumulate_i = 1'b0;
`endif
    for (int e = 0; e < 16; e++) begin
      a_i[e] = 8'(e + 3);
      b_i[e] = 8'(e + 7);
    end
    repeat (3) tick();
    vectors++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0 || c1 !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: ready=%b valid=%b c=%h, required ready=1 valid=0 c=0", ready1, valid1, c1);
    end
    reset_ni = 1'b1;
    valid_i  = 1'b0;
    tick();
    vectors++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0 || c1 !== '0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b c=%h, required ready=1 valid=0 c=0", ready1, valid1, c1);
    end
    $display("reset: ready=%b valid=%b", ready1, valid1);
  endtask

  task automatic test_unsigned_identity;
    logic [15:0][7:0]  a, b;
    logic [15:0][17:0] expv;
    int lat;
    for (int e = 0; e < 16; e++) begin
      a[e]    = (e % 5 == 0) ? 8'd1 : 8'd0;
      b[e]    = 8'(e + 1);
      expv[e] = 18'(e + 1);
    end
    ready_i = 1'b1;
    run_op(a, b, 1'b0, 1'b0, lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL identity_latency: got %0d cycles, required 4", lat);
    end
    vectors++;
    if (c1 !== expv) begin
      miscompares++;
      $display("FAIL identity_result: got %h required %h", c1, expv);
    end
    tick();
    vectors++;
    if (valid1 !== 1'b0 || ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL identity_pulse: valid=%b ready=%b, required valid=0 ready=1", valid1, ready1);
    end
  endtask

  task automatic test_signed_extremes;
    logic [15:0][7:0] a, b;
    int lat;
    logic [17:0] req [3];
    logic [7:0]  opv [3];
    logic        sgv [3];
    req[0] = 18'd65536;  opv[0] = 8'h80; sgv[0] = 1'b1;
    req[1] = 18'd65536;  opv[1] = 8'h80; sgv[1] = 1'b0;
    req[2] = 18'd260100; opv[2] = 8'hFF; sgv[2] = 1'b0;
    ready_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int e = 0; e < 16; e++) begin
        a[e] = opv[t];
        b[e] = opv[t];
      end
      run_op(a, b, sgv[t], 1'b0, lat);
      for (int e = 0; e < 16; e++) begin
        vectors++;
        if (c1[e] !== req[t]) begin
          miscompares++;
          $display("FAIL extreme_%0d elem %0d: got %0d required %0d", t, e, c1[e], req[t]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [15:0][17:0] expv;
    int lat;
    int held_bad;
    // A all 2, B = 1..16: each C row is twice the column sums of B = 56,64,72,80.
    for (int e = 0; e < 16; e++) begin
      a_i[e]  = 8'd2;
      b_i[e]  = 8'(e + 1);
      expv[e] = 18'(56 + 8*(e % 4));
    end
    signed_i = 1'b0;
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    accumulate_i = 1'b0;
`endif
    ready_i = 1'b0;
    valid_i = 1'b1;
    tick();
    for (int e = 0; e < 16; e++) begin
      a_i[e] = 8'hFF;
      b_i[e] = 8'h00;
    end
    lat = 0;
    while (valid1 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL backpressure_latency: got %0d required 4", lat);
    end
    held_bad = 0;
    for (int n = 0; n < 10; n++) begin
      vectors++;
      if (c1 !== expv || valid1 !== 1'b1 || ready1 !== 1'b0) begin
        miscompares++;
        held_bad++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b ready=%b c=%h required c=%h", n, valid1, ready1, c1, expv);
      end
      tick();
    end
    $display("backpressure: held 10 cycles, %0d bad", held_bad);
    ready_i = 1'b1;
    tick();
    vectors++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: ready=%b valid=%b required 1/0", ready1, valid1);
    end
    tick();
    valid_i = 1'b0;
    vectors++;
    if (ready1 !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_reaccept: ready=%b required 0", ready1);
    end
    lat = 0;
    while (valid1 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (c1 !== '0 || lat !== 4) begin
      miscompares++;
      $display("FAIL backpressure_second: c=%h lat=%0d required 0 and 4", c1, lat);
    end
    tick();
  endtask

  task automatic test_kstep;
    logic [15:0][7:0]  a, b;
    logic [15:0][17:0] expv;
    int lat1, lat2, lat4;
    for (int e = 0; e < 16; e++) begin
      a[e] = 8'($urandom_range(0, 255));
      b[e] = 8'($urandom_range(0, 255));
    end
    expv     = model(a, b, 1'b1);
    a_i      = a;
    b_i      = b;
    signed_i = 1'b1;
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    accumulate_i = 1'b0;
`endif
    ready_i = 1'b0;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    lat1 = -1; lat2 = -1; lat4 = -1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (valid1 === 1'b1 && lat1 < 0) lat1 = n;
      if (valid2 === 1'b1 && lat2 < 0) lat2 = n;
      if (valid4 === 1'b1 && lat4 < 0) lat4 = n;
    end
    $display("kstep: latencies %0d %0d %0d", lat1, lat2, lat4);
    vectors++;
    if (lat1 !== 4 || lat2 !== 2 || lat4 !== 1) begin
      miscompares++;
      $display("FAIL kstep_latency: got %0d/%0d/%0d required 4/2/1", lat1, lat2, lat4);
    end
    vectors++;
    if (c1 !== expv) begin
      miscompares++;
      $display("FAIL kstep1_result: got %h required %h", c1, expv);
    end
    vectors++;
    if (c2 !== expv) begin
      miscompares++;
      $display("FAIL kstep2_result: got %h required %h", c2, expv);
    end
    vectors++;
    if (c4 !== expv) begin
      miscompares++;
      $display("FAIL kstep4_result: got %h required %h", c4, expv);
    end
    ready_i = 1'b1;
    tick();
    vectors++;
    if (ready1 !== 1'b1 || ready2 !== 1'b1 || ready4 !== 1'b1) begin
      miscompares++;
      $display("FAIL kstep_idle: ready=%b%b%b required 111", ready1, ready2, ready4);
    end
  endtask

  task automatic test_reset_mid_compute;
    int rose;
    for (int e = 0; e < 16; e++) begin
      a_i[e] = 8'd1;
      b_i[e] = 8'd1;
    end
    signed_i = 1'b0;
    ready_i  = 1'b1;
    valid_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    reset_ni = 1'b0;
    #1;
    vectors++;
    if (c1 !== '0 || valid1 !== 1'b0 || ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_async: c=%h valid=%b ready=%b required 0/0/1", c1, valid1, ready1);
    end
    tick();
    reset_ni = 1'b1;
    rose = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (valid1 === 1'b1 || c1 !== '0) rose++;
    end
    $display("midreset: post-release anomalies %0d", rose);
    vectors++;
    if (rose !== 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: %0d cycles with valid or nonzero c, required 0", rose);
    end
  endtask

`ifdef SEQ_MM_ENGINE_ACCUM_EN
  task automatic test_accumulate;
    logic [15:0][7:0] a, b;
    int lat;
    logic [17:0] req [3];
    logic        acv [3];
    req[0] = 18'd5;  acv[0] = 1'b0;
    req[1] = 18'd10; acv[1] = 1'b1;
    req[2] = 18'd5;  acv[2] = 1'b0;
    for (int e = 0; e < 16; e++) begin
      a[e] = (e % 5 == 0) ? 8'd1 : 8'd0;
      b[e] = 8'd5;
    end
    ready_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      run_op(a, b, 1'b0, acv[t], lat);
      for (int e = 0; e < 16; e++) begin
        vectors++;
        if (c1[e] !== req[t]) begin
          miscompares++;
          $display("FAIL accumulate_%0d elem %0d: got %0d required %0d", t, e, c1[e], req[t]);
        end
      end
      tick();
    end
    // 260100 + 260100 = 520200, which is 258056 modulo 2^18.
    for (int e = 0; e < 16; e++) begin
      a[e] = 8'hFF;
      b[e] = 8'hFF;
    end
    run_op(a, b, 1'b0, 1'b0, lat);
    tick();
    run_op(a, b, 1'b0, 1'b1, lat);
    vectors++;
    if (c1[7] !== 18'd258056 || c1[0] !== 18'd258056) begin
      miscompares++;
      $display("FAIL accumulate_wrap: got %0d/%0d required 258056", c1[0], c1[7]);
    end
    tick();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_unsigned_identity();
    test_signed_extremes();
    test_backpressure();
    test_kstep();
    test_reset_mid_compute();
`ifdef SEQ_MM_ENGINE_ACCUM_EN
    test_accumulate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
